pll_lock_sequencer: RTL and testbench

- Controls the board PLL (50 MHz inclk0 → 100 MHz c0): pulses the PLL's areset, waits for and qualifies lock, then releases the downstream system reset.
- Retries on lock timeout and re-sequences on loss of lock. Declares a hard failure after a bounded number of retries.
- Runs entirely on the 50 MHz reference clock. The c0-domain logic synchronizes sys_reset_n locally.

---
 rtl/pll_lock_sequencer.sv | 135 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the 50 MHz reference: pulses PLL areset, qualifies lock,
// releases the downstream reset, retries on timeout and latches a hard failure.
module pll_lock_sequencer #(
    parameter int AR_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                               inclk0,
    input  logic                               reset_n,
    input  logic                               pll_locked,
    input  logic                               restart,
    output logic                               pll_areset,
    output logic                               sys_reset_n,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         state
);

    localparam int CNT_M1  = (AR_CYCLES > LOCK_TIMEOUT) ? AR_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_M1 > STABLE_CYCLES) ? CNT_M1 : STABLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic pll_areset_q, pll_areset_d;
    logic sys_reset_n_q, sys_reset_n_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // State register, counters, synchronizer and registered outputs
    always_ff @(posedge inclk0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            retry_q       <= '0;
            sync_q        <= '0;
            pll_areset_q  <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_areset_q  <= pll_areset_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
        end
    end

    // Next-state, counter and retry logic; restart overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        if (restart) begin
            state_d = ST_ASSERT;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == AR_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_SETTLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_ASSERT;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s)                state_d = ST_WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                    if (!locked_s) state_d = ST_ASSERT;
                end
                ST_FAIL: begin
                    cnt_d = cnt_q;
                end
                default: state_d = ST_ASSERT;
            endcase
            if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
        end
        // Restart clears the counter even when already in ASSERT
        if (restart || state_d != state_q) cnt_d = '0;
    end

    // Outputs decoded from the next state so they move on the same edge as the state
    always_comb begin
        pll_areset_d  = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    assign pll_areset  = pll_areset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters and
// hand-computed edge-by-edge expectations.
module tb_pll_lock_sequencer;

    logic       inclk0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_areset;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [2:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .AR_CYCLES    (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .SYNC_STAGES  (2)
    ) dut (
        .inclk0     (inclk0),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_areset (pll_areset),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count),
        .state      (state)
    );

    initial begin
        inclk0 = 1'b0;
        forever #10 inclk0 = ~inclk0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge inclk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic ar,
                           input logic srn, input logic rdy, input logic fl,
                           input logic [1:0] rc);
        chk({tag, ".state"},       32'(state),       32'(st));
        chk({tag, ".pll_areset"},  32'(pll_areset),  32'(ar));
        chk({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(srn));
        chk({tag, ".ready"},       32'(ready),       32'(rdy));
        chk({tag, ".fail"},        32'(fail),        32'(fl));
        chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
    endtask

    // Output invariants sampled away from the active edge
    always @(negedge inclk0) begin
        if (reset_n) begin
            n_assert++;
            assert (!(pll_areset && sys_reset_n)) else begin
                n_fail++;
                $error("FAIL inv_areset_sysrst: observed both high expected not both");
            end
            n_assert++;
            assert (!(ready && fail)) else begin
                n_fail++;
                $error("FAIL inv_ready_fail: observed both high expected not both");
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        restart    = 1'b0;
        step(3);
        chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Nominal bring-up: edges counted from reset release
        reset_n = 1'b1;
        step(3);  chk_all("bring_e3",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("bring_e4",  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("bring_e5",  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(7);  chk_all("bring_e12", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("bring_e13", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Loss of lock in RUN, then re-lock
        step(2);  pll_locked = 1'b0;
        step(2);  chk_all("loss_e2",   3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1);  chk_all("loss_e3",   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        pll_locked = 1'b1;
        step(4);  chk_all("relock_e4", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("relock_e5", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(7);  chk_all("relock_e12", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("relock_e13", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // One timeout, lock on the retry, glitch during SETTLE
        restart = 1'b1; pll_locked = 1'b0;
        step(1);  chk_all("retry_e0",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        restart = 1'b0;
        step(23); chk_all("retry_e23", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("retry_e24", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        pll_locked = 1'b1;
        step(5);  chk_all("retry_e29", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(2);  pll_locked = 1'b0;
        step(1);  pll_locked = 1'b1;
        step(1);  chk_all("glitch_e33", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1);  chk_all("glitch_e34", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1);  chk_all("glitch_e35", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(7);  chk_all("glitch_e42", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1);  chk_all("glitch_e43", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Timeout through all retries to FAIL
        restart = 1'b1; pll_locked = 1'b0;
        step(1);  chk_all("tmo_e0",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        restart = 1'b0;
        step(24); chk_all("tmo_e24", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        step(23); chk_all("tmo_e47", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1);  chk_all("tmo_e48", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        step(23); chk_all("tmo_e71", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1);  chk_all("tmo_e72", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        pll_locked = 1'b1;
        step(10); chk_all("fail_hold", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);

        // Restart out of FAIL
        restart = 1'b1;
        step(1);  chk_all("rstf_e0",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        restart = 1'b0;
        step(12); chk_all("rstf_e12", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("rstf_e13", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Restart held for several edges keeps ASSERT with a cleared counter
        restart = 1'b1;
        step(3);  chk_all("hold_e3",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        restart = 1'b0;
        step(3);  chk_all("hold_r3",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);  chk_all("hold_r4",  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(2);  chk_all("hold_r6",  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset mid-SETTLE, checked between clock edges
        #5 reset_n = 1'b0;
        #1 chk_all("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        #2 reset_n = 1'b1;
        step(2);  chk_all("post_rst_e2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(2);  chk_all("post_rst_e4", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
